// File: rtl/kmp_pkg.sv
// ---------------------------------------------------------------------------
// kmp_pkg
// Shared definitions for the KMP prefix-table builder and its neighbours.
//   PAT_LEN_MAX     : maximum pattern length in characters
//   CHAR_W          : character width in bits
//   IDX_W           : width of length / index fields
//   kmp_pb_state_t  : builder FSM states
//   kmp_state_enc_t : 4-bit state code also used by the matcher's debug port
// ---------------------------------------------------------------------------
package kmp_pkg;

    localparam int PAT_LEN_MAX = 8;
    localparam int CHAR_W      = 8;
    localparam int IDX_W       = $clog2(PAT_LEN_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } kmp_pb_state_t;

    typedef logic [3:0] kmp_state_enc_t;

    // Widens the builder state to the 4-bit code shared with the matcher.
    function automatic kmp_state_enc_t kmpEncodeState(input kmp_pb_state_t s);
        return {2'b00, s};
    endfunction

endpackage

// File: rtl/kmp_prefix_builder_if.sv
// ---------------------------------------------------------------------------
// kmp_prefix_builder_if
// Bundles the builder's control, pattern-memory read and table-write signals.
//   start/pat_len        : build request and requested pattern length
//   pat_addr/pat_data    : pattern memory read (data one cycle after address)
//   lps_we/addr/data     : LPS table write port toward the matcher
//   busy/done/table_valid: status
// Modports:
//   slave  : the prefix builder itself
//   master : the surrounding system (requester, pattern memory, table RAM)
// ---------------------------------------------------------------------------
interface kmp_prefix_builder_if #(
    parameter int IDX_W  = kmp_pkg::IDX_W,
    parameter int CHAR_W = kmp_pkg::CHAR_W
);
    logic              start;
    logic [IDX_W-1:0]  pat_len;
    logic [IDX_W-1:0]  pat_addr;
    logic [CHAR_W-1:0] pat_data;
    logic              lps_we;
    logic [IDX_W-1:0]  lps_addr;
    logic [IDX_W-1:0]  lps_data;
    logic              busy;
    logic              done;
    logic              table_valid;

    modport slave (
        input  start, pat_len, pat_data,
        output pat_addr, lps_we, lps_addr, lps_data, busy, done, table_valid
    );

    modport master (
        output start, pat_len, pat_data,
        input  pat_addr, lps_we, lps_addr, lps_data, busy, done, table_valid
    );

endinterface

// File: rtl/kmp_pattern_regfile.sv
// ---------------------------------------------------------------------------
// kmp_pattern_regfile
// Local copy of the pattern plus a shadow of the LPS values written so far,
// so the prefix-function fallback never has to read the matcher's table RAM.
//   clk                     : clock
//   i_patWe/Waddr/Wdata     : pattern store write port
//   i_patRaddrA/B, o_patRdataA/B : two combinational pattern reads
//   i_lpsWe/Waddr/Wdata     : LPS shadow write port
//   i_lpsRaddr, o_lpsRdata  : combinational LPS shadow read
// ---------------------------------------------------------------------------
module kmp_pattern_regfile #(
    parameter int PAT_LEN_MAX = kmp_pkg::PAT_LEN_MAX,
    parameter int CHAR_W      = kmp_pkg::CHAR_W,
    parameter int IDX_W       = kmp_pkg::IDX_W,
    parameter int AW          = (PAT_LEN_MAX > 1) ? $clog2(PAT_LEN_MAX) : 1
) (
    input  logic              clk,
    input  logic              i_patWe,
    input  logic [AW-1:0]     i_patWaddr,
    input  logic [CHAR_W-1:0] i_patWdata,
    input  logic [AW-1:0]     i_patRaddrA,
    input  logic [AW-1:0]     i_patRaddrB,
    output logic [CHAR_W-1:0] o_patRdataA,
    output logic [CHAR_W-1:0] o_patRdataB,
    input  logic              i_lpsWe,
    input  logic [AW-1:0]     i_lpsWaddr,
    input  logic [IDX_W-1:0]  i_lpsWdata,
    input  logic [AW-1:0]     i_lpsRaddr,
    output logic [IDX_W-1:0]  o_lpsRdata
);
    import kmp_pkg::*;

    logic [CHAR_W-1:0] r_patMem [PAT_LEN_MAX];
    logic [IDX_W-1:0]  r_lpsMem [PAT_LEN_MAX];

    // Pattern characters arrive one per cycle while the builder is loading.
    // Contents are plain storage, so no reset is applied.
    always_ff @(posedge clk) begin
        if (i_patWe) begin
            r_patMem[i_patWaddr] <= i_patWdata;
        end
    end

    // Every LPS value sent to the matcher is mirrored here so the fallback
    // step can look up lps[len-1] in the same cycle.
    always_ff @(posedge clk) begin
        if (i_lpsWe) begin
            r_lpsMem[i_lpsWaddr] <= i_lpsWdata;
        end
    end

    assign o_patRdataA = r_patMem[i_patRaddrA];
    assign o_patRdataB = r_patMem[i_patRaddrB];
    assign o_lpsRdata  = r_lpsMem[i_lpsRaddr];

endmodule

// File: rtl/kmp_prefix_builder.sv
// ---------------------------------------------------------------------------
// kmp_prefix_builder
// Builds the KMP failure (LPS) table for the active pattern: loads the pattern
// from pattern memory, runs the prefix function and streams one LPS entry per
// address, in ascending order, into the matcher's table RAM.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : start/pat_len request, pattern read, LPS write, status
// Optional build macro KMP_PREFIX_DBG_EN adds:
//   actual_state : 4-bit encoded FSM state
//   build_cycles : cycles from accepted start to done, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module kmp_prefix_builder #(
    parameter int PAT_LEN_MAX = kmp_pkg::PAT_LEN_MAX,
    parameter int CHAR_W      = kmp_pkg::CHAR_W,
    parameter int IDX_W       = $clog2(PAT_LEN_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    kmp_prefix_builder_if.slave   bus
`ifdef KMP_PREFIX_DBG_EN
    ,
    output logic [3:0]            actual_state,
    output logic [15:0]           build_cycles
`endif
);
    import kmp_pkg::*;

    localparam int               AW      = (PAT_LEN_MAX > 1) ? $clog2(PAT_LEN_MAX) : 1;
    localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(PAT_LEN_MAX);
    localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

    kmp_pb_state_t     r_state;
    logic [IDX_W-1:0]  r_m;
    logic [IDX_W-1:0]  r_patAddr;
    logic              r_issuing;
    logic              r_capValid;
    logic [IDX_W-1:0]  r_capIdx;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_len;
    logic              r_first;
    logic              r_lpsWe;
    logic [IDX_W-1:0]  r_lpsAddr;
    logic [IDX_W-1:0]  r_lpsData;
    logic              r_busy;
    logic              r_done;
    logic              r_tableValid;

    logic [IDX_W-1:0]  w_mClamped;
    logic [CHAR_W-1:0] w_patI;
    logic [CHAR_W-1:0] w_patLen;
    logic [IDX_W-1:0]  w_lpsPrev;
    logic              w_capWe;
    logic              w_stepWe;
    logic [IDX_W-1:0]  w_stepAddr;
    logic [IDX_W-1:0]  w_stepData;
    logic [IDX_W-1:0]  w_nextI;
    logic              w_tableDone;

    assign w_mClamped = (bus.pat_len > MAX_LEN) ? MAX_LEN : bus.pat_len;
    assign w_capWe    = (r_state == ST_LOAD) && r_capValid;

    kmp_pattern_regfile #(
        .PAT_LEN_MAX (PAT_LEN_MAX),
        .CHAR_W      (CHAR_W),
        .IDX_W       (IDX_W),
        .AW          (AW)
    ) u_regfile (
        .clk         (clk),
        .i_patWe     (w_capWe),
        .i_patWaddr  (AW'(r_capIdx)),
        .i_patWdata  (bus.pat_data),
        .i_patRaddrA (AW'(r_i)),
        .i_patRaddrB (AW'(r_len)),
        .o_patRdataA (w_patI),
        .o_patRdataB (w_patLen),
        .i_lpsWe     (w_stepWe),
        .i_lpsWaddr  (AW'(w_stepAddr)),
        .i_lpsWdata  (w_stepData),
        .i_lpsRaddr  (AW'(r_len - ONE)),
        .o_lpsRdata  (w_lpsPrev)
    );

    // One prefix-function step per COMPUTE cycle. The very first cycle only
    // emits lps[0]=0; afterwards a match extends len, a mismatch with len=0
    // emits 0, and a mismatch with len>0 falls back without writing. The
    // same decision drives both the shadow copy and the outgoing write.
    always_comb begin
        w_stepWe    = 1'b0;
        w_stepAddr  = r_i;
        w_stepData  = '0;
        w_nextI     = r_i + ONE;
        w_tableDone = 1'b0;
        if (r_state == ST_COMPUTE) begin
            if (r_first) begin
                w_stepWe    = 1'b1;
                w_stepAddr  = '0;
                w_tableDone = (r_m == ONE);
            end else if (w_patI == w_patLen) begin
                w_stepWe    = 1'b1;
                w_stepData  = r_len + ONE;
                w_tableDone = (w_nextI == r_m);
            end else if (r_len == '0) begin
                w_stepWe    = 1'b1;
                w_tableDone = (w_nextI == r_m);
            end
        end
    end

    // Main control FSM. LOAD keeps a one-deep pipeline (address issued this
    // cycle, captured two edges later) because pattern memory answers one
    // cycle after the address. start is only looked at in IDLE, so repeated
    // requests while busy simply fall on the floor.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_m          <= '0;
            r_patAddr    <= '0;
            r_issuing    <= 1'b0;
            r_capValid   <= 1'b0;
            r_capIdx     <= '0;
            r_i          <= ONE;
            r_len        <= '0;
            r_first      <= 1'b0;
            r_lpsWe      <= 1'b0;
            r_lpsAddr    <= '0;
            r_lpsData    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tableValid <= 1'b0;
        end else begin
            r_lpsWe <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_m        <= w_mClamped;
                        r_busy     <= 1'b1;
                        r_patAddr  <= '0;
                        r_issuing  <= 1'b1;
                        r_capValid <= 1'b0;
                        r_i        <= ONE;
                        r_len      <= '0;
                        r_first    <= 1'b1;
                        if (w_mClamped == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state      <= ST_LOAD;
                            r_tableValid <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    r_capValid <= r_issuing;
                    r_capIdx   <= r_patAddr;
                    if (r_issuing) begin
                        if (r_patAddr == r_m - ONE) begin
                            r_issuing <= 1'b0;
                        end else begin
                            r_patAddr <= r_patAddr + ONE;
                        end
                    end
                    if (r_capValid && (r_capIdx == r_m - ONE)) begin
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    r_first <= 1'b0;
                    if (w_stepWe) begin
                        r_lpsWe   <= 1'b1;
                        r_lpsAddr <= w_stepAddr;
                        r_lpsData <= w_stepData;
                    end
                    if (!r_first) begin
                        if (w_stepWe) begin
                            r_i   <= w_nextI;
                            r_len <= w_stepData;
                        end else begin
                            r_len <= w_lpsPrev;
                        end
                    end
                    if (w_tableDone) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_tableValid <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pat_addr    = r_patAddr;
    assign bus.lps_we      = r_lpsWe;
    assign bus.lps_addr    = r_lpsAddr;
    assign bus.lps_data    = r_lpsData;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.table_valid = r_tableValid;

`ifdef KMP_PREFIX_DBG_EN
    logic [15:0] r_buildCycles;

    // Build-time counter for bring-up: cleared when a start is accepted,
    // counts every busy cycle, then holds until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buildCycles <= '0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_buildCycles <= '0;
        end else if (r_busy && (r_buildCycles != 16'hFFFF)) begin
            r_buildCycles <= r_buildCycles + 16'd1;
        end
    end

    assign build_cycles = r_buildCycles;
    assign actual_state = kmpEncodeState(r_state);
`endif

endmodule

// File: tb/tb_kmp_prefix_builder.sv
// ---------------------------------------------------------------------------
// tb_kmp_prefix_builder
// Self-checking bench for kmp_prefix_builder. A pattern memory model answers
// reads one cycle late; a brute-force LPS reference computed straight from
// the prefix/suffix definition provides every expected table entry.
// ---------------------------------------------------------------------------
module tb_kmp_prefix_builder;

   logic clk;
   logic rst;

   kmp_prefix_builder_if bus ();

`ifdef KMP_PREFIX_DBG_EN
   logic [3:0]  actualState;
   logic [15:0] buildCycles;
`endif

   kmp_prefix_builder dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef KMP_PREFIX_DBG_EN
      ,
      .actual_state (actualState),
      .build_cycles (buildCycles)
`endif
   );

   logic [7:0] patMem [0:7];
   logic [2:0] addrDly;
   int         refLps [0:7];
   int         wAddrQ[$];
   int         wDataQ[$];
   int         wCycQ[$];
   int         edgeCnt;
   int         startEdge;
   int         doneCnt;
   int         totalCnt;
   int         badCnt;
   int         savedSize;

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to express latencies relative to the start edge.
   always @(posedge clk) edgeCnt++;

   // Pattern memory model: the word for the address shown in one cycle is
   // presented during the following cycle.
   always @(negedge clk) begin
      bus.pat_data = patMem[addrDly];
      addrDly      = bus.pat_addr[2:0];
   end

   // Record every table write and every done pulse seen by the matcher side.
   always @(negedge clk) begin
      if (bus.lps_we === 1'b1) begin
         wAddrQ.push_back(int'(bus.lps_addr));
         wDataQ.push_back(int'(bus.lps_data));
         wCycQ.push_back(edgeCnt - startEdge + 1);
      end
      if (bus.done === 1'b1) doneCnt++;
   end

   // Last-resort guard so a stuck design still ends the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalCnt++;
      assert (observed === expected)
      else begin
         badCnt++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_pat_addr"},    int'(bus.pat_addr),    0);
      checkOutput({tag, "_lps_we"},      int'(bus.lps_we),      0);
      checkOutput({tag, "_lps_addr"},    int'(bus.lps_addr),    0);
      checkOutput({tag, "_lps_data"},    int'(bus.lps_data),    0);
      checkOutput({tag, "_busy"},        int'(bus.busy),        0);
      checkOutput({tag, "_done"},        int'(bus.done),        0);
      checkOutput({tag, "_table_valid"}, int'(bus.table_valid), 0);
   endtask

   task automatic loadPattern(input string s);
      for (int k = 0; k < s.len(); k++) patMem[k] = s[k];
   endtask

   task automatic loadRandom(input int alphabet);
      for (int k = 0; k < 8; k++) patMem[k] = 8'h41 + 8'($urandom_range(0, alphabet - 1));
   endtask

   // Reference: longest proper prefix of pat[0..k] that is also its suffix,
   // found by trying every length directly.
   task automatic buildRef(input int m);
      for (int k = 0; k < m; k++) begin
         int best;
         best = 0;
         for (int l = 1; l <= k; l++) begin
            bit same;
            same = 1'b1;
            for (int j = 0; j < l; j++)
               if (patMem[j] != patMem[k - l + 1 + j]) same = 1'b0;
            if (same) best = l;
         end
         refLps[k] = best;
      end
   endtask

   // Called at a negedge; returns #1 after the edge that accepts start.
   task automatic applyStimulus(input int lenReq);
      wAddrQ.delete();
      wDataQ.delete();
      wCycQ.delete();
      bus.pat_len = 4'(lenReq);
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      startEdge = edgeCnt;
      bus.start = 1'b0;
   endtask

   task automatic runAndCheck(input string tag, input int lenReq, input int repulseCyc);
      int m;
      int doneCyc;
      int doneBefore;
      bit found;
      m = (lenReq > 8) ? 8 : lenReq;
      buildRef(m);
      doneBefore = doneCnt;
      found      = 1'b0;
      doneCyc    = 0;
      applyStimulus(lenReq);
      for (int c = 1; c <= 3 * m + 3 && !found; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checkOutput({tag, "_busyRise"}, int'(bus.busy), 1);
            if (m > 0) checkOutput({tag, "_tvCleared"}, int'(bus.table_valid), 0);
         end
         bus.start = (repulseCyc != 0 && c == repulseCyc) ? 1'b1 : 1'b0;
         if (bus.done === 1'b1) begin
            found   = 1'b1;
            doneCyc = c;
         end
      end
      bus.start = 1'b0;
      checkOutput({tag, "_doneInTime"}, int'(found), 1);
      if (found) begin
         if (m == 0) checkOutput({tag, "_doneCycle"}, doneCyc, 2);
         checkOutput({tag, "_tvAtDone"},   int'(bus.table_valid), 1);
         checkOutput({tag, "_busyAtDone"}, int'(bus.busy), 0);
         @(negedge clk);
         checkOutput({tag, "_donePulse"}, int'(bus.done), 0);
         checkOutput({tag, "_tvHeld"},    int'(bus.table_valid), 1);
      end
      checkOutput({tag, "_writeCount"}, wAddrQ.size(), m);
      for (int k = 0; k < wAddrQ.size() && k < m; k++) begin
         checkOutput($sformatf("%s_addr%0d", tag, k), wAddrQ[k], k);
         checkOutput($sformatf("%s_lps%0d", tag, k),  wDataQ[k], refLps[k]);
         checkOutput($sformatf("%s_weAfterLoad%0d", tag, k), int'(wCycQ[k] > m + 1), 1);
      end
      checkOutput({tag, "_donePulses"}, doneCnt - doneBefore, 1);
   endtask

   // Directed scenarios first, then random patterns over a small alphabet.
   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.pat_len = '0;
      addrDly     = '0;
      edgeCnt     = 0;
      startEdge   = 0;
      doneCnt     = 0;
      totalCnt    = 0;
      badCnt      = 0;
      for (int k = 0; k < 8; k++) patMem[k] = 8'h41;

      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] directed patterns");
      loadPattern("ABAB");
      runAndCheck("abab", 4, 0);
      loadPattern("AAACAAAA");
      runAndCheck("aaacaaaa", 8, 0);
      loadPattern("ABCD");
      runAndCheck("abcd", 4, 0);
      runAndCheck("emptyLen", 0, 0);
      loadRandom(2);
      runAndCheck("clampLen", 12, 0);

      $display("[TB] start re-pulse during COMPUTE");
      loadRandom(2);
      runAndCheck("repulse", 8, 12);
      repeat (3) @(negedge clk);
      checkOutput("repulse_idleBusy", int'(bus.busy), 0);

      $display("[TB] reset during COMPUTE");
      loadRandom(2);
      applyStimulus(4);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkResetOutputs("midReset");
      savedSize = wAddrQ.size();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("midReset_noWrites", wAddrQ.size(), savedSize);
      loadPattern("AAAA");
      runAndCheck("aaaa", 4, 0);

      $display("[TB] random patterns");
      for (int n = 0; n < 20; n++) begin
         loadRandom(3);
         runAndCheck($sformatf("rand%0d", n), $urandom_range(0, 12), 0);
      end

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
